// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer stage.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries with combinational head and flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_buffer_stage.sv
// Fetch stage: issues in-order instruction requests, buffers the responses and
// discards responses belonging to a path abandoned by an execute-stage redirect.
module fetch_buffer_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            stall_f,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            valid_f,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_plus4_f
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]   outst_reg, outst_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;

    entry_t          push_entry;
    entry_t          head_entry;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_push;
    logic            fifo_pop;

    logic [XLEN-1:0] target_aligned;
    logic [CW:0]     occupancy;
    logic            req_fire;
    logic            rsp_live;
    logic            rsp_keep;
    logic            rsp_drop;

    assign target_aligned = {pc_target_e[XLEN-1:2], 2'b00};
    assign occupancy      = {1'b0, outst_reg} + {1'b0, fifo_count};

    // Every accepted request has a reserved buffer slot, so responses can never overflow.
    assign imem_req_valid = !srst && !pcsrc_e && !fifo_full && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign rsp_live = imem_rsp_valid && (outst_reg != '0);
    assign rsp_keep = rsp_live && (drop_cnt_reg == '0);
    assign rsp_drop = rsp_live && (drop_cnt_reg != '0);

    assign fifo_push  = rsp_keep && !pcsrc_e;
    assign fifo_pop   = !fifo_empty && !stall_f && !pcsrc_e;
    assign push_entry = '{pc: rsp_pc_reg, instr: imem_rsp_data};

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        outst_next    = outst_reg + CW'(req_fire) - CW'(rsp_live);
        drop_cnt_next = drop_cnt_reg;
        if (pcsrc_e) begin
            fetch_pc_next = target_aligned;
            rsp_pc_next   = target_aligned;
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_next = outst_reg - CW'(rsp_live);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + XLEN'(4);
            end
            if (rsp_keep) begin
                rsp_pc_next = rsp_pc_reg + XLEN'(4);
            end
            if (rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            outst_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            outst_reg    <= outst_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .srst      (srst),
        .flush     (pcsrc_e),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign valid_f    = !fifo_empty;
    assign pc_f       = fifo_empty ? '0 : head_entry.pc;
    assign instr_f    = fifo_empty ? '0 : head_entry.instr;
    assign pc_plus4_f = pc_f + XLEN'(4);

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// stream-level model (expected request and delivered-pc sequences, memory queue).
module tb_fetch_buffer_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        srst;
    logic        stall_f;
    logic        pcsrc_e;
    logic [31:0] pc_target_e;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid_f;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;

    always #5 clk = ~clk;

    fetch_buffer_stage #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .srst           (srst),
        .stall_f        (stall_f),
        .pcsrc_e        (pcsrc_e),
        .pc_target_e    (pc_target_e),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_f        (valid_f),
        .instr_f        (instr_f),
        .pc_f           (pc_f),
        .pc_plus4_f     (pc_plus4_f)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        memq[$];
    int          last_due;
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;

    int          ready_pct = 100;
    int          stall_pct = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          redir_pm  = 0;
    bit          redir_now = 1'b0;
    logic [31:0] redir_tgt = '0;
    bit          verbose   = 1'b1;

    logic        s_req_fire;
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_valid_f;
    logic        s_consumed;
    logic [31:0] s_pc_f;
    logic [31:0] s_pc_plus4;
    int          n_accepted;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, sample 1ns later, update the model
    // with what the next rising edge will do.
    task automatic cycle_step();
        int lat;
        int due;
        @(negedge clk);
        imem_req_ready = ($urandom_range(99) < ready_pct);
        stall_f        = ($urandom_range(99) < stall_pct);
        if (redir_now) begin
            pcsrc_e     = 1'b1;
            pc_target_e = redir_tgt;
            redir_now   = 1'b0;
        end else if (redir_pm > 0 && $urandom_range(999) < redir_pm) begin
            pcsrc_e     = 1'b1;
            pc_target_e = $urandom;
        end else begin
            pcsrc_e     = 1'b0;
            pc_target_e = $urandom;
        end
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (pcsrc_e) check("no_req_during_redirect", 32'(imem_req_valid), 32'd0);
        s_req_valid = imem_req_valid;
        s_req_fire  = imem_req_valid && imem_req_ready;
        s_req_addr  = imem_req_addr;
        s_valid_f   = valid_f;
        s_pc_f      = pc_f;
        s_pc_plus4  = pc_plus4_f;
        s_consumed  = valid_f && !stall_f && !pcsrc_e;
        if (imem_rsp_valid) memq.delete(0);
        if (s_req_fire) begin
            check("req_addr", imem_req_addr, exp_req);
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{due: due, data: mem_word(imem_req_addr)});
            check("outstanding_bound", 32'(memq.size() <= DEPTH), 32'd1);
            exp_req = exp_req + 32'd4;
            n_accepted++;
        end
        if (s_consumed) begin
            check("pc_f", pc_f, exp_pc);
            check("instr_f", instr_f, mem_word(exp_pc));
            check("pc_plus4_f", pc_plus4_f, exp_pc + 32'd4);
            if (verbose) $display("[TB] cycle %0d consume pc=0x%08h instr=0x%08h", cyc, pc_f, instr_f);
            exp_pc = exp_pc + 32'd4;
        end
        if (pcsrc_e) begin
            if (verbose) $display("[TB] cycle %0d redirect to 0x%08h", cyc, pc_target_e);
            exp_pc  = {pc_target_e[31:2], 2'b00};
            exp_req = {pc_target_e[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic apply_reset();
        srst           = 1'b1;
        stall_f        = 1'b0;
        pcsrc_e        = 1'b0;
        pc_target_e    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        memq.delete();
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid_f", 32'(valid_f), 32'd0);
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        srst       = 1'b0;
        last_due   = 0;
        cyc        = 1;
        exp_pc     = 32'h0;
        exp_req    = 32'h0;
        n_accepted = 0;
    endtask

    initial begin
        int          first_req;
        int          first_valid;
        logic [31:0] first_pc;
        logic [31:0] first_pc4;
        bit          saw_wrap;
        bit          after_wrap;

        srst = 1'b1;
        // Basic streaming: ready, latency 1, no stall.
        ready_pct = 100; stall_pct = 0; lat_min = 1; lat_max = 1;
        apply_reset();
        first_req = -1; first_valid = -1; first_pc = '1; first_pc4 = '1;
        for (int i = 0; i < 10; i++) begin
            cycle_step();
            if (s_req_fire && first_req < 0) first_req = cyc - 1;
            if (s_valid_f && first_valid < 0) begin
                first_valid = cyc - 1;
                first_pc    = s_pc_f;
                first_pc4   = s_pc_plus4;
            end
        end
        check("first_req_cycle", 32'(first_req), 32'd1);
        check("first_valid_cycle", 32'(first_valid), 32'd3);
        check("first_pc", first_pc, 32'h0);
        check("first_pc_plus4", first_pc4, 32'h4);

        // Downstream held: the buffer fills and requests stop at DEPTH.
        stall_pct = 100;
        apply_reset();
        for (int i = 0; i < 12; i++) cycle_step();
        check("stall_req_count", 32'(n_accepted), 32'(DEPTH));
        check("stall_req_valid_low", 32'(s_req_valid), 32'd0);
        check("stall_head_valid", 32'(s_valid_f), 32'd1);
        check("stall_head_pc", s_pc_f, 32'h0);
        stall_pct = 0;
        for (int i = 0; i < 10; i++) cycle_step();

        // Redirect with two stale requests in flight at latency 3.
        lat_min = 3; lat_max = 3;
        apply_reset();
        cycle_step();
        cycle_step();
        redir_now = 1'b1; redir_tgt = 32'h100;
        cycle_step();
        cycle_step();
        check("redirect_flush_empty", 32'(s_valid_f), 32'd0);
        first_pc = '1;
        for (int i = 0; i < 12; i++) begin
            cycle_step();
            if (s_valid_f && first_pc == '1) first_pc = s_pc_f;
        end
        check("redirect_first_pc", first_pc, 32'h100);

        // Misaligned redirect target.
        lat_min = 1; lat_max = 1;
        redir_now = 1'b1; redir_tgt = 32'h203;
        cycle_step();
        cycle_step();
        check("align_req_fire", 32'(s_req_fire), 32'd1);
        check("align_req_addr", s_req_addr, 32'h200);
        for (int i = 0; i < 6; i++) cycle_step();

        // Address wrap at the top of the address space.
        redir_now = 1'b1; redir_tgt = 32'hFFFF_FFF8;
        saw_wrap = 1'b0; after_wrap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle_step();
            if (s_consumed && after_wrap) begin
                check("wrap_next_pc", s_pc_f, 32'h0);
                after_wrap = 1'b0;
            end
            if (s_consumed && s_pc_f == 32'hFFFF_FFFC) begin
                check("wrap_pc_plus4", s_pc_plus4, 32'h0);
                saw_wrap   = 1'b1;
                after_wrap = 1'b1;
            end
        end
        check("wrap_seen", 32'(saw_wrap), 32'd1);

        // Asynchronous reset with three requests outstanding.
        lat_min = 5; lat_max = 5;
        apply_reset();
        cycle_step(); cycle_step(); cycle_step();
        ready_pct = 0;
        cycle_step();
        check("pre_reset_outstanding", 32'(memq.size()), 32'd3);
        #2;
        srst = 1'b1;
        #1;
        check("async_reset_valid_f", 32'(valid_f), 32'd0);
        check("async_reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_reset_pc_f", pc_f, 32'h0);
        apply_reset();
        memq.push_back('{due: 0, data: 32'hDEAD_BEEF});
        cycle_step();
        cycle_step();
        check("late_rsp_ignored", 32'(s_valid_f), 32'd0);
        ready_pct = 100; lat_min = 1; lat_max = 1;
        first_req = -1;
        for (int i = 0; i < 10; i++) begin
            cycle_step();
            if (s_req_fire && first_req < 0) begin
                first_req = 0;
                check("restart_addr", s_req_addr, 32'h0);
            end
        end

        // Randomized traffic with stalls, variable latency and redirects.
        verbose = 1'b0;
        ready_pct = 70; stall_pct = 30; lat_min = 1; lat_max = 4; redir_pm = 20;
        apply_reset();
        for (int i = 0; i < 3000; i++) cycle_step();
        stall_pct = 80; ready_pct = 90; lat_max = 6;
        for (int i = 0; i < 1500; i++) cycle_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
